// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the register-bus round-robin arbiter.
// Default bus structs are used when the arbiter is not given custom types.
package reg_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   } reg_bus_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   } reg_bus_rsp_t;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/reg_rr_sel.sv
// Combinational find-first-set over the valid vector,
// starting the search at i_ptr and wrapping modulo NumReq.
module reg_rr_sel #(
   parameter int unsigned NumReq = 2,
   parameter int unsigned IdxW   = reg_arb_pkg::idx_width(NumReq)
) (
   input  logic [NumReq-1:0] i_valid,
   input  logic [IdxW-1:0]   i_ptr,
   output logic [IdxW-1:0]   o_gnt_idx,
   output logic              o_any_valid
);

   int unsigned w_j;

   always_comb begin
      o_gnt_idx   = '0;
      o_any_valid = 1'b0;
      w_j         = 0;
      for (int unsigned k = 0; k < NumReq; k++) begin
         w_j = (32'(i_ptr) + k) % NumReq;
         if (!o_any_valid && i_valid[w_j]) begin
            o_any_valid = 1'b1;
            o_gnt_idx   = IdxW'(w_j);
         end
      end
   end

endmodule

// File: rtl/reg_rr_arbiter.sv
// Round-robin arbiter sharing one register-bus target among NumReq
// masters; holds the grant until ready, optional stall timeout.
module reg_rr_arbiter #(
   parameter int unsigned NumReq        = 2,
   parameter int unsigned TimeoutCycles = 0,
   parameter type reg_req_t = reg_arb_pkg::reg_bus_req_t,
   parameter type reg_rsp_t = reg_arb_pkg::reg_bus_rsp_t
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  reg_req_t [NumReq-1:0] reg_req_i,
   output reg_rsp_t [NumReq-1:0] reg_rsp_o,
   output reg_req_t              reg_req_o,
   input  reg_rsp_t              reg_rsp_i,
   output logic                  busy_o,
   output logic                  timeout_o
);

   import reg_arb_pkg::*;

   localparam int unsigned IdxW = idx_width(NumReq);
   localparam int unsigned TW   =
      (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);
   localparam logic [TW-1:0]   TLimit  = TW'(TimeoutCycles);

   state_e            r_state, w_state_nxt;
   logic [IdxW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
   logic [IdxW-1:0]   r_locked_idx, w_locked_nxt;
   logic [TW-1:0]     r_tcnt, w_tcnt_nxt;
   logic [NumReq-1:0] w_valid;
   logic [NumReq-1:0] w_rsp_rdy;
   logic [IdxW-1:0]   w_gnt_idx;
   logic [IdxW-1:0]   w_sel_idx;
   logic              w_any_valid;
   logic              w_act;
   logic              w_abort;

   function automatic logic [IdxW-1:0] adv(input logic [IdxW-1:0] idx);
      return (idx == LastIdx) ? '0 : idx + 1'b1;
   endfunction

   always_comb begin
      w_valid = '0;
      for (int unsigned i = 0; i < NumReq; i++)
         w_valid[i] = reg_req_i[i].valid;
   end

   reg_rr_sel #(
      .NumReq (NumReq),
      .IdxW   (IdxW)
   ) u_sel (
      .i_valid     (w_valid),
      .i_ptr       (r_rr_ptr),
      .o_gnt_idx   (w_gnt_idx),
      .o_any_valid (w_any_valid)
   );

   assign busy_o    = (r_state == BUSY);
   assign w_sel_idx = busy_o ? r_locked_idx : w_gnt_idx;
   assign w_act     = busy_o ? reg_req_i[r_locked_idx].valid : w_any_valid;
   assign w_abort   = (TimeoutCycles != 0) && busy_o && w_act &&
                      !reg_rsp_i.ready && (r_tcnt == TLimit);

   always_comb begin
      reg_req_o = '0;
      reg_rsp_o = '0;
      timeout_o = 1'b0;
      if (w_act) begin
         reg_req_o            = reg_req_i[w_sel_idx];
         reg_rsp_o[w_sel_idx] = reg_rsp_i;
      end
      // Abort: hide the request downstream, answer the master with an error
      if (w_abort) begin
         reg_req_o.valid            = 1'b0;
         reg_rsp_o[w_sel_idx]       = '0;
         reg_rsp_o[w_sel_idx].error = 1'b1;
         reg_rsp_o[w_sel_idx].ready = 1'b1;
         timeout_o                  = 1'b1;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_rr_ptr_nxt = r_rr_ptr;
      w_locked_nxt = r_locked_idx;
      w_tcnt_nxt   = r_tcnt;
      unique case (r_state)
         IDLE: begin
            if (w_any_valid) begin
               if (reg_rsp_i.ready) begin
                  w_rr_ptr_nxt = adv(w_gnt_idx);
               end else begin
                  w_locked_nxt = w_gnt_idx;
                  w_tcnt_nxt   = TW'(1);
                  w_state_nxt  = BUSY;
               end
            end
         end
         BUSY: begin
            if (!w_act) begin
               w_state_nxt = IDLE;
               w_tcnt_nxt  = '0;
            end else if (reg_rsp_i.ready || w_abort) begin
               w_rr_ptr_nxt = adv(r_locked_idx);
               w_tcnt_nxt   = '0;
               w_state_nxt  = IDLE;
            end else if (r_tcnt != '1) begin
               w_tcnt_nxt = r_tcnt + 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state      <= IDLE;
         r_rr_ptr     <= '0;
         r_locked_idx <= '0;
         r_tcnt       <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_rr_ptr     <= w_rr_ptr_nxt;
         r_locked_idx <= w_locked_nxt;
         r_tcnt       <= w_tcnt_nxt;
      end
   end

   always_comb begin
      w_rsp_rdy = '0;
      for (int unsigned i = 0; i < NumReq; i++)
         w_rsp_rdy[i] = reg_rsp_o[i].ready;
   end

   a_req_stable: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      (reg_req_o.valid && !reg_rsp_i.ready)
      |=> (!reg_req_o.valid || $stable(reg_req_o)));

   a_one_ready: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      $onehot0(w_rsp_rdy));

   a_lock_valid: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      (r_state == BUSY) |-> reg_req_i[r_locked_idx].valid);

endmodule

// File: tb/tb_reg_rr_arbiter.sv
// Bench for reg_rr_arbiter: a 2-master instance with timeout 4
// and a 3-master instance without timeout, checked by a scoreboard.
module tb_reg_rr_arbiter;

   import reg_arb_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   reg_bus_req_t [1:0] req_a;
   reg_bus_rsp_t [1:0] rsp_a;
   reg_bus_req_t       dreq_a;
   reg_bus_rsp_t       drsp_a;
   logic               busy_a, to_a, rdy_a;

   reg_bus_req_t [2:0] req_b;
   reg_bus_rsp_t [2:0] rsp_b;
   reg_bus_req_t       dreq_b;
   reg_bus_rsp_t       drsp_b;
   logic               busy_b, to_b, rdy_b;

   typedef struct {
      int          idx;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   int   checks = 0;
   int   errors = 0;

   logic [31:0] addr_a[2];
   logic [31:0] addr_b[3];

   reg_rr_arbiter #(.NumReq(2), .TimeoutCycles(4)) u_dut_a (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .reg_req_i (req_a),
      .reg_rsp_o (rsp_a),
      .reg_req_o (dreq_a),
      .reg_rsp_i (drsp_a),
      .busy_o    (busy_a),
      .timeout_o (to_a)
   );

   reg_rr_arbiter #(.NumReq(3), .TimeoutCycles(0)) u_dut_b (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .reg_req_i (req_b),
      .reg_rsp_o (rsp_b),
      .reg_req_o (dreq_b),
      .reg_rsp_i (drsp_b),
      .busy_o    (busy_b),
      .timeout_o (to_b)
   );

   function automatic logic [31:0] rd(input logic [31:0] a);
      return {a[15:0], 16'hBEEF};
   endfunction

   function automatic reg_bus_req_t mk(input logic [31:0] a);
      reg_bus_req_t r;
      r       = '0;
      r.addr  = a;
      r.wdata = a ^ 32'h0000_5555;
      r.wstrb = 4'hF;
      return r;
   endfunction

   // Target models: read data derived from address, ready from the bench
   always_comb begin
      drsp_a       = '0;
      drsp_a.rdata = rd(dreq_a.addr);
      drsp_a.ready = rdy_a;
   end

   always_comb begin
      drsp_b       = '0;
      drsp_b.rdata = rd(dreq_b.addr);
      drsp_b.ready = rdy_b;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 2; i++) begin
            if (rsp_a[i].ready) begin
               exp_t e;
               checks++;
               if (q_a.size() == 0) begin
                  errors++;
                  $display("FAIL sb_a: unexpected ready at master %0d", i);
               end else begin
                  e = q_a.pop_front();
                  if (i != e.idx || rsp_a[i].error !== e.err ||
                      rsp_a[i].rdata !== e.rdata) begin
                     errors++;
                     $display("FAIL sb_a: got m%0d err=%b rd=%h want m%0d err=%b rd=%h",
                              i, rsp_a[i].error, rsp_a[i].rdata,
                              e.idx, e.err, e.rdata);
                  end
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 3; i++) begin
            if (rsp_b[i].ready) begin
               exp_t e;
               checks++;
               if (q_b.size() == 0) begin
                  errors++;
                  $display("FAIL sb_b: unexpected ready at master %0d", i);
               end else begin
                  e = q_b.pop_front();
                  if (i != e.idx || rsp_b[i].error !== e.err ||
                      rsp_b[i].rdata !== e.rdata) begin
                     errors++;
                     $display("FAIL sb_b: got m%0d err=%b rd=%h want m%0d err=%b rd=%h",
                              i, rsp_b[i].error, rsp_b[i].rdata,
                              e.idx, e.err, e.rdata);
                  end
               end
            end
         end
      end
   end

   task automatic test_reset();
      addr_a = '{32'h0000_0100, 32'h0000_0200};
      addr_b = '{32'h0000_1000, 32'h0000_2000, 32'h0000_3000};
      for (int i = 0; i < 2; i++) req_a[i] = mk(addr_a[i]);
      for (int i = 0; i < 3; i++) req_b[i] = mk(addr_b[i]);
      rdy_a = 1'b0;
      rdy_b = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy_a, to_a, busy_b, to_b} !== 4'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b want 0000",
                  {busy_a, to_a, busy_b, to_b});
      end
      checks++;
      if (dreq_a !== '0 || rsp_a !== '0) begin
         errors++;
         $display("FAIL reset_bus_a: got req=%h rsp=%h want 0", dreq_a, rsp_a);
      end
      checks++;
      if (dreq_b !== '0 || rsp_b !== '0) begin
         errors++;
         $display("FAIL reset_bus_b: got req=%h rsp=%h want 0", dreq_b, rsp_b);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_alternate();
      req_a[0].valid = 1'b1;
      req_a[1].valid = 1'b1;
      rdy_a = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
         end
         q_a.push_back('{k % 2, 1'b0, rd(addr_a[k % 2])});
         @(negedge clk);
         checks++;
         if (dreq_a.addr !== addr_a[k % 2] || dreq_a.valid !== 1'b1) begin
            errors++;
            $display("FAIL alt_grant%0d: got addr=%h v=%b want addr=%h v=1",
                     k, dreq_a.addr, dreq_a.valid, addr_a[k % 2]);
         end
         checks++;
         if (rsp_a[1 - (k % 2)] !== '0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL alt_other%0d: got rsp=%h busy=%b want 0",
                     k, rsp_a[1 - (k % 2)], busy_a);
         end
      end
      @(posedge clk); #1;
      req_a[0].valid = 1'b0;
      req_a[1].valid = 1'b0;
      rdy_a = 1'b0;
      @(negedge clk);
      checks++;
      if (dreq_a !== '0 || rsp_a !== '0 || busy_a !== 1'b0) begin
         errors++;
         $display("FAIL idle_zero: got req=%h rsp=%h busy=%b want 0",
                  dreq_a, rsp_a, busy_a);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_single_wait();
      req_a[1].valid = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
         end
         if (c == 3) begin
            rdy_a = 1'b1;
            q_a.push_back('{1, 1'b0, rd(addr_a[1])});
         end
         @(negedge clk);
         checks++;
         if (busy_a !== (c > 0)) begin
            errors++;
            $display("FAIL wait_busy%0d: got %b want %b", c, busy_a, c > 0);
         end
         checks++;
         if (dreq_a !== req_a[1] || rsp_a[0] !== '0) begin
            errors++;
            $display("FAIL wait_fwd%0d: got req=%h rsp0=%h want req=%h rsp0=0",
                     c, dreq_a, rsp_a[0], req_a[1]);
         end
      end
      @(posedge clk); #1;
      req_a[1].valid = 1'b0;
      rdy_a = 1'b0;
      @(negedge clk);
      checks++;
      if (busy_a !== 1'b0) begin
         errors++;
         $display("FAIL wait_done: got busy=%b want 0", busy_a);
      end
      @(posedge clk); #1;
      // Pointer back at 0: master 0 must win a tie
      req_a[0].valid = 1'b1;
      req_a[1].valid = 1'b1;
      rdy_a = 1'b1;
      q_a.push_back('{0, 1'b0, rd(addr_a[0])});
      @(negedge clk);
      checks++;
      if (dreq_a.addr !== addr_a[0]) begin
         errors++;
         $display("FAIL wait_ptr: got addr=%h want %h", dreq_a.addr, addr_a[0]);
      end
      @(posedge clk); #1;
      req_a[0].valid = 1'b0;
      req_a[1].valid = 1'b0;
      rdy_a = 1'b0;
   endtask

   task automatic test_grant_held();
      req_a[0].valid = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
            req_a[1].valid = 1'b1;
         end
         if (c == 3) begin
            rdy_a = 1'b1;
            q_a.push_back('{0, 1'b0, rd(addr_a[0])});
         end
         @(negedge clk);
         checks++;
         if (dreq_a.addr !== addr_a[0] || rsp_a[1].ready !== 1'b0) begin
            errors++;
            $display("FAIL hold%0d: got addr=%h rdy1=%b want addr=%h rdy1=0",
                     c, dreq_a.addr, rsp_a[1].ready, addr_a[0]);
         end
      end
      @(posedge clk); #1;
      req_a[0].valid = 1'b0;
      q_a.push_back('{1, 1'b0, rd(addr_a[1])});
      @(negedge clk);
      checks++;
      if (dreq_a.addr !== addr_a[1] || busy_a !== 1'b0) begin
         errors++;
         $display("FAIL hold_next: got addr=%h busy=%b want addr=%h busy=0",
                  dreq_a.addr, busy_a, addr_a[1]);
      end
      @(posedge clk); #1;
      req_a[1].valid = 1'b0;
      rdy_a = 1'b0;
   endtask

   task automatic test_timeout();
      req_a[0].valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
         end
         if (c == 4) q_a.push_back('{0, 1'b1, 32'h0});
         @(negedge clk);
         checks++;
         if (to_a !== (c == 4) || dreq_a.valid !== (c != 4)) begin
            errors++;
            $display("FAIL tmo%0d: got to=%b v=%b want to=%b v=%b",
                     c, to_a, dreq_a.valid, c == 4, c != 4);
         end
      end
      @(posedge clk); #1;
      req_a[0].valid = 1'b0;
      @(negedge clk);
      checks++;
      if (busy_a !== 1'b0 || to_a !== 1'b0) begin
         errors++;
         $display("FAIL tmo_idle: got busy=%b to=%b want 0 0", busy_a, to_a);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_ready_at_limit();
      req_a[1].valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
         end
         if (c == 4) begin
            rdy_a = 1'b1;
            q_a.push_back('{1, 1'b0, rd(addr_a[1])});
         end
         @(negedge clk);
         checks++;
         if (to_a !== 1'b0 || dreq_a.valid !== 1'b1 || busy_a !== (c > 0)) begin
            errors++;
            $display("FAIL lim%0d: got to=%b v=%b busy=%b want 0 1 %b",
                     c, to_a, dreq_a.valid, busy_a, c > 0);
         end
      end
      @(posedge clk); #1;
      req_a[1].valid = 1'b0;
      rdy_a = 1'b0;
      @(negedge clk);
      checks++;
      if (busy_a !== 1'b0) begin
         errors++;
         $display("FAIL lim_idle: got busy=%b want 0", busy_a);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_busy();
      req_b[1].valid = 1'b1;
      rdy_b = 1'b1;
      q_b.push_back('{1, 1'b0, rd(addr_b[1])});
      @(negedge clk);
      checks++;
      if (dreq_b.addr !== addr_b[1]) begin
         errors++;
         $display("FAIL rst_pre: got addr=%h want %h", dreq_b.addr, addr_b[1]);
      end
      @(posedge clk); #1;
      req_b[1].valid = 1'b0;
      req_b[0].valid = 1'b1;
      req_b[2].valid = 1'b1;
      rdy_b = 1'b0;
      @(negedge clk);
      checks++;
      if (dreq_b.addr !== addr_b[2]) begin
         errors++;
         $display("FAIL rst_ptr2: got addr=%h want %h", dreq_b.addr, addr_b[2]);
      end
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         checks++;
         if (busy_b !== 1'b1 || to_b !== 1'b0 || dreq_b.addr !== addr_b[2]) begin
            errors++;
            $display("FAIL rst_stall%0d: got busy=%b to=%b addr=%h want 1 0 %h",
                     c, busy_b, to_b, dreq_b.addr, addr_b[2]);
         end
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy_b !== 1'b0 || rsp_b[2].ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_async: got busy=%b rdy2=%b want 0 0",
                  busy_b, rsp_b[2].ready);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      req_b[1].valid = 1'b1;
      rdy_b = 1'b1;
      q_b.push_back('{0, 1'b0, rd(addr_b[0])});
      @(negedge clk);
      checks++;
      if (dreq_b.addr !== addr_b[0]) begin
         errors++;
         $display("FAIL rst_win0: got addr=%h want %h", dreq_b.addr, addr_b[0]);
      end
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) req_b[i].valid = 1'b0;
      rdy_b = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not end in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_alternate();
      test_single_wait();
      test_grant_held();
      test_timeout();
      test_ready_at_limit();
      test_reset_mid_busy();
      checks++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d/%0d pending want 0/0",
                  q_a.size(), q_b.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
